// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: control codes, FSM state encodings and slice modes.
// Used by the ALU decoder and the sliced execution unit.
package alu_ctrl_pkg;

   localparam int unsigned ALU_CTRL_W = 3;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_LUI  = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_RSV6 = 3'b110,
      ALU_RSV7 = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   typedef enum logic [1:0] {
      SL_ADD = 2'd0,
      SL_AND = 2'd1,
      SL_OR  = 2'd2
   } slice_mode_e;

endpackage

// File: rtl/sliced_alu_if.sv
// Request/response bundle of the sliced ALU; the overflow signal exists only
// when ALU_OVERFLOW_EN is defined.
interface sliced_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
`ifdef ALU_OVERFLOW_EN
   logic             overflow;
`endif

   modport master (
      output in_valid, alu_control, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero
`ifdef ALU_OVERFLOW_EN
      , input overflow
`endif
   );

   modport slave (
      input  in_valid, alu_control, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero
`ifdef ALU_OVERFLOW_EN
      , output overflow
`endif
   );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit add/and/or stage; also reports carry into its MSB
// so the top slice can derive signed overflow.
module alu_slice
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned SLICE = 8
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             cin_i,
   input  slice_mode_e      mode_i,
   output logic [SLICE-1:0] res_o,
   output logic             cout_o,
   output logic             cmsb_o
);
   logic [SLICE:0] sum;

   always_comb begin
      sum    = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
      cout_o = sum[SLICE];
      cmsb_o = a_i[SLICE-1] ^ b_i[SLICE-1] ^ sum[SLICE-1];
      case (mode_i)
         SL_AND:  res_o = a_i & b_i;
         SL_OR:   res_o = a_i | b_i;
         default: res_o = sum[SLICE-1:0];
      endcase
   end
endmodule

// File: rtl/sliced_alu.sv
// Multi-cycle ALU computing WIDTH bits one SLICE per cycle through a single alu_slice.
// Define ALU_OVERFLOW_EN to expose the registered signed-overflow flag.
module sliced_alu
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   sliced_alu_if.slave  bus
);
   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   alu_state_e       state_q, state_d;
   slice_mode_e      mode_q, mode_d;
   logic             slt_q, slt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
`ifdef ALU_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   logic [SLICE-1:0] a_sl, b_sl, s_res;
   logic             s_cout, s_cmsb, ovf_w;

   assign a_sl  = a_q[cnt_q*SLICE +: SLICE];
   assign b_sl  = b_q[cnt_q*SLICE +: SLICE];
   assign ovf_w = s_cmsb ^ s_cout;

   alu_slice #(.SLICE(SLICE)) u_slice (
      .a_i    (a_sl),
      .b_i    (b_sl),
      .cin_i  (carry_q),
      .mode_i (mode_q),
      .res_o  (s_res),
      .cout_o (s_cout),
      .cmsb_o (s_cmsb)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      slt_d   = slt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
`ifdef ALU_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               zero_d  = 1'b0;
`ifdef ALU_OVERFLOW_EN
               ovf_d   = 1'b0;
`endif
               a_d     = bus.src_a;
               b_d     = bus.src_b;
               carry_d = 1'b0;
               mode_d  = SL_ADD;
               slt_d   = 1'b0;
               case (bus.alu_control)
                  ALU_SUB: begin
                     b_d     = ~bus.src_b;
                     carry_d = 1'b1;
                  end
                  ALU_SLT: begin
                     b_d     = ~bus.src_b;
                     carry_d = 1'b1;
                     slt_d   = 1'b1;
                  end
                  ALU_AND: mode_d = SL_AND;
                  ALU_OR:  mode_d = SL_OR;
                  ALU_LUI: begin
                     // LUI is an OR of zero with the shifted immediate
                     a_d    = '0;
                     b_d    = WIDTH'({bus.src_b[15:0], 16'h0000});
                     mode_d = SL_OR;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            carry_d = s_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            res_d   = (res_q >> SLICE) | (WIDTH'(s_res) << (WIDTH - SLICE));
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               if (slt_q) res_d = WIDTH'(s_res[SLICE-1] ^ ovf_w);
               zero_d  = (res_d == '0);
`ifdef ALU_OVERFLOW_EN
               ovf_d   = (mode_q == SL_ADD) ? ovf_w : 1'b0;
`endif
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= SL_ADD;
         slt_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         slt_q   <= slt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
`ifdef ALU_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = res_q;
   assign bus.zero      = zero_q;
`ifdef ALU_OVERFLOW_EN
   assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_sliced_alu.sv
// Directed self-checking bench for sliced_alu (default 32-bit, 8-bit slices).
// Overflow checks are compiled in only when ALU_OVERFLOW_EN is defined.
module tb_sliced_alu;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   sliced_alu_if #(.WIDTH(32)) bus ();

   sliced_alu #(.WIDTH(32), .SLICE(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic ov, output int lat);
      @(negedge clk);
      bus.alu_control = code;
      bus.src_a       = a;
      bus.src_b       = b;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         tests++;
         fails++;
         $display("FAIL timeout waiting out_valid: got none, required within 20 cycles");
      end
      res = bus.result;
      z   = bus.zero;
`ifdef ALU_OVERFLOW_EN
      ov  = bus.overflow;
`else
      ov  = 1'b0;
`endif
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
      tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h, required 00000000", bus.result); end
      tests++; if (bus.zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b, required 0", bus.zero); end
   endtask

   task automatic test_add();
      logic [31:0] r; logic z, ov; int lat;
      do_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, r, z, ov, lat);
      tests++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL add_ovf_result: got %h, required 80000000", r); end
      tests++; if (z !== 1'b0) begin fails++; $display("FAIL add_ovf_zero: got %b, required 0", z); end
      tests++; if (lat !== 4) begin fails++; $display("FAIL add_latency: got %0d, required 4", lat); end
`ifdef ALU_OVERFLOW_EN
      tests++; if (ov !== 1'b1) begin fails++; $display("FAIL add_overflow: got %b, required 1", ov); end
`endif
      do_op(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, r, z, ov, lat);
      tests++; if (r !== 32'h0 || z !== 1'b1) begin fails++; $display("FAIL add110_wrap: got %h/z%b, required 00000000/z1", r, z); end
`ifdef ALU_OVERFLOW_EN
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL add110_overflow: got %b, required 0", ov); end
`endif
      do_op(3'b111, 32'h1234_5678, 32'h0FED_CBA9, r, z, ov, lat);
      tests++; if (r !== 32'h2222_2221) begin fails++; $display("FAIL add111_result: got %h, required 22222221", r); end
   endtask

   task automatic test_sub();
      logic [31:0] r; logic z, ov; int lat;
      do_op(3'b001, 32'h0000_0005, 32'h0000_0005, r, z, ov, lat);
      tests++; if (r !== 32'h0) begin fails++; $display("FAIL sub_eq_result: got %h, required 00000000", r); end
      tests++; if (z !== 1'b1) begin fails++; $display("FAIL sub_eq_zero: got %b, required 1", z); end
`ifdef ALU_OVERFLOW_EN
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL sub_eq_overflow: got %b, required 0", ov); end
`endif
      do_op(3'b001, 32'h0000_0000, 32'h0000_0001, r, z, ov, lat);
      tests++; if (r !== 32'hFFFF_FFFF || z !== 1'b0) begin fails++; $display("FAIL sub_neg: got %h/z%b, required ffffffff/z0", r, z); end
   endtask

   task automatic test_slt();
      logic [31:0] r; logic z, ov; int lat;
      do_op(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, r, z, ov, lat);
      tests++; if (r !== 32'h1) begin fails++; $display("FAIL slt_neg: got %h, required 00000001", r); end
      do_op(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, r, z, ov, lat);
      tests++; if (r !== 32'h1 || z !== 1'b0) begin fails++; $display("FAIL slt_ovf: got %h/z%b, required 00000001/z0", r, z); end
`ifdef ALU_OVERFLOW_EN
      tests++; if (ov !== 1'b1) begin fails++; $display("FAIL slt_ovf_flag: got %b, required 1", ov); end
`endif
      do_op(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, r, z, ov, lat);
      tests++; if (r !== 32'h0 || z !== 1'b1) begin fails++; $display("FAIL slt_swapped: got %h/z%b, required 00000000/z1", r, z); end
   endtask

   task automatic test_logic();
      logic [31:0] r; logic z, ov; int lat;
      do_op(3'b100, 32'h1234_5678, 32'h0000_ABCD, r, z, ov, lat);
      tests++; if (r !== 32'hABCD_0000) begin fails++; $display("FAIL lui: got %h, required abcd0000", r); end
      do_op(3'b011, 32'hF0F0_0000, 32'h0000_FFFF, r, z, ov, lat);
      tests++; if (r !== 32'hF0F0_FFFF) begin fails++; $display("FAIL or: got %h, required f0f0ffff", r); end
      do_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, r, z, ov, lat);
      tests++; if (r !== 32'h00F0_1200) begin fails++; $display("FAIL and: got %h, required 00f01200", r); end
`ifdef ALU_OVERFLOW_EN
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL and_overflow: got %b, required 0", ov); end
`endif
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      bus.alu_control = 3'b000; bus.src_a = 32'd1; bus.src_b = 32'd2; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) begin lat = i; break; end
      end
      tests++; if (lat !== 4) begin fails++; $display("FAIL bp_first_latency: got %0d, required 4", lat); end
      bus.alu_control = 3'b000; bus.src_a = 32'd10; bus.src_b = 32'd20; bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++;
         if (bus.result !== 32'd3 || bus.zero !== 1'b0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got res=%h z=%b ov=%b ir=%b, required 00000003 0 1 0",
                     i, bus.result, bus.zero, bus.out_valid, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got ir=%b ov=%b, required 1 0", bus.in_ready, bus.out_valid); end
      @(posedge clk); #1 bus.in_valid = 1'b0;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_reaccept: got ir=%b, required 0", bus.in_ready); end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) begin lat = i; break; end
      end
      tests++; if (lat !== 4 || bus.result !== 32'd30) begin fails++; $display("FAIL bp_second: got lat=%0d res=%h, required 4 0000001e", lat, bus.result); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] r; logic z, ov; int lat;
      @(negedge clk);
      bus.alu_control = 3'b000; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'h0000_0001; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++; if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin fails++; $display("FAIL midrst_clear: got ov=%b res=%h, required 0 00000000", bus.out_valid, bus.result); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin fails++; $display("FAIL midrst_after: got ir=%b ov=%b res=%h, required 1 0 00000000", bus.in_ready, bus.out_valid, bus.result); end
      do_op(3'b000, 32'h0000_0001, 32'h0000_0001, r, z, ov, lat);
      tests++; if (r !== 32'h2 || lat !== 4) begin fails++; $display("FAIL midrst_next_add: got %h lat=%0d, required 00000002 lat=4", r, lat); end
      do_op(3'b001, 32'h0000_0007, 32'h0000_0002, r, z, ov, lat);
      tests++; if (r !== 32'h5) begin fails++; $display("FAIL midrst_next_sub: got %h, required 00000005", r); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_control = 3'b000;
      bus.src_a = 32'h0;
      bus.src_b = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_sub();
      test_slt();
      test_logic();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sliced_alu.md
# sliced_alu

Multi-cycle, area-reduced execution unit that consumes the 3-bit ALU control code produced by the ALU decoder and computes a WIDTH-bit result one SLICE-bit slice per cycle. Sits in the execute stage between the operand multiplexers and the writeback/branch-compare logic. Uses a valid/ready handshake on both sides so the controller can stall on it.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE and ≥ 32
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation
- alu_control  input  3  operation code, sampled on accept
- src_a  input  WIDTH  operand A, sampled on accept
- src_b  input  WIDTH  operand B, sampled on accept
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- overflow  output  1  signed overflow; present only with ALU_OVERFLOW_EN

## Operation
- Codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LUI, 101 SLT (signed), 110/111 executed as ADD.
- Accept: in_valid && in_ready. Captures code, A, B. LUI preloads A=0, B={src_b[15:0],16'b0} and runs as OR. SUB/SLT store ~B and initial carry 1; others carry 0.
- FSM: IDLE → RUN on accept; RUN → RUN while slice counter < NSLICE-1; RUN → DONE after slice NSLICE-1; DONE → IDLE when out_ready.
- RUN: each cycle processes slice[count] (LSB first), carry chained through a carry register, slice result shifted into the result register.
- SLT: after final slice, result = {WIDTH-1 zeros, sign(A-B) ^ ovf}.
- Signed overflow for ADD/SUB/SLT = carry into MSB ^ carry out of MSB, taken from the final slice; 0 for AND/OR/LUI.
- Carry out of MSB discarded; arithmetic is modulo 2^WIDTH.
- in_ready = (state == IDLE). out_valid = (state == DONE). No new accept in the same cycle as output handshake.
- result, zero, overflow held stable while out_valid && !out_ready.
- Reset (any state, including mid-RUN): state IDLE, in-flight op discarded, result=0, zero=0, overflow=0, out_valid=0, in_ready=1 once rst_n high.

## Timing
- Accept on edge E; slices processed on edges E+1 … E+NSLICE; out_valid high after edge E+NSLICE (4 cycles for defaults).
- Earliest next accept: edge after output handshake; back-to-back throughput one op per NSLICE+2 cycles.
- zero/overflow registered, valid exactly when out_valid.
- in_ready and out_valid are pure state decodes (no combinational path from in_valid/out_ready).

## Configuration
- ALU_OVERFLOW_EN defined: overflow port exists and is driven as specified.
- Undefined: no overflow port; overflow is still computed internally for SLT only, not registered as an output.

## Structure
- Shared package alu_ctrl_pkg: the eight ALU control code constants, FSM state encodings (IDLE, RUN, DONE), code width 3; shared with the ALU decoder.
- One sub-module: alu_slice — combinational SLICE-bit add/and/or with carry-in, carry-out, and carry-into-MSB for the top slice; instantiated once, reused every cycle.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, zero 0, overflow 1 (macro on), out_valid exactly 4 cycles after accept.
- SUB 0x00000005 − 0x00000005 → result 0, zero 1, overflow 0; SUB 0 − 1 → 0xFFFFFFFF.
- SLT A=0xFFFFFFFF, B=0x00000001 → 1; SLT A=0x80000000, B=0x7FFFFFFF → 1 (overflow case); swapped → 0.
- LUI src_b=0x0000ABCD, src_a=0x12345678 → 0xABCD0000; OR 0xF0F00000|0x0000FFFF → 0xF0F0FFFF; code 111 → ADD result.
- Backpressure: out_ready low 3 cycles after out_valid → result/zero held, in_ready stays 0, in_valid ignored; accept resumes cycle after handshake.
- rst_n low during 2nd RUN cycle → out_valid 0, result 0, in_ready 1 after release; next op completes correctly with no residual carry.
